// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter in front of a shared 4:1 select.
// Captures the winning requester's word into an output register, presents it
// on a valid/ready port and returns a one-cycle ack when the consumer takes it.
// Optional feature: define MUX4_ARB_BURST_EN to let a requester that still
// has req asserted keep the grant for up to MAX_BURST consecutive beats.
module mux4_rr_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] in_data,
    output logic [3:0]     ack,
    output logic [1:0]     sel,
    output logic [3:0]     grant,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    input  logic           out_ready
);

    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("mux4_rr_arbiter: MAX_BURST must be >= 1");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_d;
    logic [1:0]     ptr, ptr_d;
    logic [1:0]     sel_d;
    logic [3:0]     grant_d;
    logic           out_valid_d;
    logic [W-1:0]   out_data_d;
    logic [1:0]     g;
    logic           accept;

`ifdef MUX4_ARB_BURST_EN
    localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    logic [BCW-1:0] burst_cnt, burst_cnt_d;
`endif

    // First set request at or after ptr, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign accept = (state == BUSY) && out_valid && out_ready;

    // Ack goes back to the granted requester in the same cycle the beat is taken.
    assign ack = accept ? grant : 4'b0000;

    // State and output registers; reset drops any pending beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            grant     <= 4'b0000;
            sel       <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef MUX4_ARB_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            grant     <= grant_d;
            sel       <= sel_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
`ifdef MUX4_ARB_BURST_EN
            burst_cnt <= burst_cnt_d;
`endif
        end
    end

    // Next-state logic: grant in IDLE, hold everything stable in BUSY until accepted.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        grant_d     = grant;
        sel_d       = sel;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        g           = rr_pick(req, ptr);
`ifdef MUX4_ARB_BURST_EN
        burst_cnt_d = burst_cnt;
`endif
        case (state)
            IDLE: begin
                grant_d = 4'b0000;
`ifdef MUX4_ARB_BURST_EN
                // A burst in progress regrants the same requester unconditionally.
                if (burst_cnt != '0) begin
                    g = sel;
                end
                if (req != 4'b0000 || burst_cnt != '0) begin
`else
                if (req != 4'b0000) begin
`endif
                    grant_d     = 4'b0001 << g;
                    sel_d       = g;
                    out_data_d  = in_data[g*W +: W];
                    out_valid_d = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                out_valid_d = 1'b1;
                if (accept) begin
                    grant_d     = 4'b0000;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef MUX4_ARB_BURST_EN
                    if (req[sel] && (int'(burst_cnt) < MAX_BURST - 1)) begin
                        burst_cnt_d = burst_cnt + BCW'(1);
                    end else begin
                        burst_cnt_d = '0;
                        ptr_d       = sel + 2'd1;
                    end
`else
                    ptr_d = sel + 2'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
